// File: rtl/display_pkg.sv
// display_pkg: scan FSM states and seven-segment patterns shared by the display blocks.
package display_pkg;
   typedef enum logic [1:0] {S_BLANK_U, S_SHOW_U, S_BLANK_D, S_SHOW_D} scan_state_t;
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_DASH  = 7'h40;
   localparam logic [6:0] SEG_BLANK = 7'h00;
endpackage

// File: rtl/module_bcd_7seg.sv
// module_bcd_7seg: combinational BCD to {g,f,e,d,c,b,a} decoder; non-BCD codes show a dash.
module module_bcd_7seg
   import display_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);
   always_comb begin
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end
endmodule

// File: rtl/module_display_scan.sv
// module_display_scan: two-digit seven-segment scan controller with inter-digit blanking
// and once-per-frame sampling of the displayed number.
module module_display_scan
   import display_pkg::*;
#(
   parameter int REFRESH_DIV  = 27000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] uni,
   input  logic [3:0] dec,
   input  logic       blank_lz,
   output logic       load_u,
   output logic       load_d,
   output logic [3:0] digit,
   output logic [6:0] seg
);
   localparam int CW = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);

   generate
      if (!(REFRESH_DIV > BLANK_CYCLES && BLANK_CYCLES >= 1)) begin : g_bad_params
         $error("module_display_scan: need REFRESH_DIV > BLANK_CYCLES >= 1");
      end
   endgenerate

   scan_state_t   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    u_q, u_d, d_q, d_d, digit_q, digit_d;
   logic          lz_q, lz_d, load_u_q, load_u_d, load_d_q, load_d_d;
   logic [6:0]    seg_q, seg_d, dec_seg;
   logic          blank, last, frame, show_u, show_d;
   logic [3:0]    sel;

   assign blank  = state_q == S_BLANK_U || state_q == S_BLANK_D;
   assign last   = blank ? cnt_q == BLANK_LAST : cnt_q == SLOT_LAST;
   assign frame  = state_q == S_BLANK_U && cnt_q == '0;
   assign show_u = state_q == S_SHOW_U;
   // a suppressed leading zero keeps its slot time so brightness does not change
   assign show_d = state_q == S_SHOW_D && !(lz_q && d_q == 4'd0);
   assign sel    = state_q == S_SHOW_D ? d_q : u_q;

   module_bcd_7seg u_dec (.bcd(sel), .seg(dec_seg));

   always_comb begin
      state_d  = !last ? state_q :
                 state_q == S_BLANK_U ? S_SHOW_U :
                 state_q == S_SHOW_U  ? S_BLANK_D :
                 state_q == S_BLANK_D ? S_SHOW_D : S_BLANK_U;
      cnt_d    = (last && !blank) ? '0 : cnt_q + 1'b1;
      u_d      = frame ? uni : u_q;
      d_d      = frame ? dec : d_q;
      lz_d     = frame ? blank_lz : lz_q;
      load_u_d = show_u;
      load_d_d = show_d;
      digit_d  = (show_u || show_d) ? sel : 4'd0;
      seg_d    = (show_u || show_d) ? dec_seg : SEG_BLANK;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_BLANK_U;
         cnt_q    <= '0;
         u_q      <= '0;
         d_q      <= '0;
         lz_q     <= 1'b0;
         load_u_q <= 1'b0;
         load_d_q <= 1'b0;
         digit_q  <= '0;
         seg_q    <= SEG_BLANK;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         u_q      <= u_d;
         d_q      <= d_d;
         lz_q     <= lz_d;
         load_u_q <= load_u_d;
         load_d_q <= load_d_d;
         digit_q  <= digit_d;
         seg_q    <= seg_d;
      end
   end

   assign load_u = load_u_q;
   assign load_d = load_d_q;
   assign digit  = digit_q;
   assign seg    = seg_q;
endmodule

// File: tb/tb_module_display_scan.sv
// tb_module_display_scan: directed frame-by-frame checks of strobes, digit and segments
// with REFRESH_DIV=8, BLANK_CYCLES=2, plus a randomized soak.
module tb_module_display_scan;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] uni = 4'd3, dec = 4'd7;
   logic       blank_lz = 1'b0;
   logic       load_u, load_d;
   logic [3:0] digit;
   logic [6:0] seg;
   int         n_vec = 0, n_err = 0;
   logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

   module_display_scan #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n), .uni(uni), .dec(dec), .blank_lz(blank_lz),
      .load_u(load_u), .load_d(load_d), .digit(digit), .seg(seg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got {lu,ld,digit,seg}=%h want %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // one frame starting at the first load_u cycle; next-frame inputs change mid SHOW_U
   task automatic frame(input string tag, input int ncyc,
                        input logic [3:0] eu, input logic [6:0] su,
                        input logic [3:0] ed, input logic [6:0] sd, input logic eld,
                        input logic [3:0] nu, input logic [3:0] nd, input logic nlz);
      for (int p = 0; p < ncyc; p++) begin
         logic [12:0] e;
         step();
         if (p == 2) begin
            uni = nu;
            dec = nd;
            blank_lz = nlz;
         end
         e = p < 6 ? {2'b10, eu, su} : (p >= 8 && p < 14) ? {1'b0, eld, ed, sd} : 13'd0;
         chk($sformatf("%s p%0d", tag, p), {load_u, load_d, digit, seg}, e);
      end
   endtask

   task automatic lead_in(input string tag);
      for (int t = 1; t <= 2; t++) begin
         step();
         chk($sformatf("%s lead%0d", tag, t), {load_u, load_d, digit, seg}, 13'd0);
      end
   endtask

   initial begin
      logic [3:0] cu, cd, nu, nd;
      logic       clz, nlz;
      repeat (2) @(negedge clk);
      chk("reset", {load_u, load_d, digit, seg}, 13'd0);
      rst_n = 1'b1;
      lead_in("start");
      frame("f0_37",   16, 4'd3, 7'h4F, 4'd7, 7'h07, 1'b1, 4'd5, 4'd7, 1'b0);
      frame("f1_57",   16, 4'd5, 7'h6D, 4'd7, 7'h07, 1'b1, 4'd3, 4'd0, 1'b1);
      frame("f2_lz",   16, 4'd3, 7'h4F, 4'd0, 7'h00, 1'b0, 4'd3, 4'd0, 1'b0);
      frame("f3_nolz", 16, 4'd3, 7'h4F, 4'd0, 7'h3F, 1'b1, 4'hC, 4'd9, 1'b0);
      frame("f4_dash", 16, 4'hC, 7'h40, 4'd9, 7'h6F, 1'b1, 4'd8, 4'hF, 1'b1);
      frame("f5_lzf",  16, 4'd8, 7'h7F, 4'hF, 7'h40, 1'b1, 4'd0, 4'd0, 1'b1);
      frame("f6_00",   16, 4'd0, 7'h3F, 4'd0, 7'h00, 1'b0, 4'd1, 4'd2, 1'b0);
      frame("f7_12",   16, 4'd1, 7'h06, 4'd2, 7'h5B, 1'b1, 4'd6, 4'd4, 1'b0);
      frame("f8_part", 10, 4'd6, 7'h7D, 4'd4, 7'h66, 1'b1, 4'd9, 4'd1, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("async_rst", {load_u, load_d, digit, seg}, 13'd0);
      step();
      chk("rst_hold", {load_u, load_d, digit, seg}, 13'd0);
      rst_n = 1'b1;
      lead_in("restart");
      cu = 4'd9; cd = 4'd1; clz = 1'b0;
      nu = 4'($urandom_range(0, 15));
      nd = 4'($urandom_range(0, 15));
      nlz = 1'($urandom_range(0, 1));
      frame("f9_91", 16, cu, 7'h6F, cd, 7'h06, 1'b1, nu, nd, nlz);
      for (int f = 0; f < 1000; f++) begin
         logic sup;
         cu = nu; cd = nd; clz = nlz;
         nu = 4'($urandom_range(0, 15));
         nd = 4'($urandom_range(0, 15));
         nlz = 1'($urandom_range(0, 1));
         sup = clz && cd == 4'd0;
         frame($sformatf("rnd%0d", f), 16, cu, seg_tab[cu],
               sup ? 4'd0 : cd, sup ? 7'h00 : seg_tab[cd], !sup, nu, nd, nlz);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
